// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles into 16-bit words with valid/ready handshakes on both sides.
// Defining NIBBLE_PARITY_EN adds a word_par output that carries the XOR of each emitted word.
module nibble_packer #(
  parameter int MSN_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  nib_in,
  input  logic        nib_valid,
  output logic        nib_ready,
  input  logic        flush,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [2:0]  nib_cnt
`ifdef NIBBLE_PARITY_EN
  ,output logic       word_par
`endif
);

  typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} state_t;

  state_t      state_q, state_d;
  logic [3:0]  nib_q [3];
  logic [3:0]  nib_d [3];
  logic [15:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        flush_pend_q, flush_pend_d;
  logic        par_q, par_d;

  logic        out_free;
  logic        accept;
  logic        flush_req;
  logic        load;
  logic [2:0]  fill_cnt;
  logic [3:0]  slot [4];
  logic [15:0] packed_word;

  // A pending flush blocks new nibbles so the flushed word holds exactly what was stored.
  assign out_free  = !word_valid_q || word_ready;
  assign nib_ready = ((state_q != FILL3) || out_free) && !flush_pend_q;
  assign accept    = nib_valid && nib_ready;
  assign nib_cnt   = {1'b0, state_q};
  assign fill_cnt  = nib_cnt + {2'b00, accept};
  assign flush_req = flush || flush_pend_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < 3) begin : g_stored
        assign slot[gi] = (3'(gi) < nib_cnt) ? nib_q[gi] :
                          ((3'(gi) == nib_cnt) && accept) ? nib_in : 4'h0;
      end else begin : g_last
        assign slot[gi] = ((state_q == FILL3) && accept) ? nib_in : 4'h0;
      end
      if (MSN_FIRST != 0) begin : g_msn
        assign packed_word[15 - 4*gi -: 4] = slot[gi];
      end else begin : g_lsn
        assign packed_word[4*gi +: 4] = slot[gi];
      end
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    nib_d        = nib_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    flush_pend_d = flush_pend_q;
    par_d        = par_q;
    load         = 1'b0;

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    if (accept && (state_q == FILL3)) begin
      load         = 1'b1;
      state_d      = FILL0;
      flush_pend_d = 1'b0;
    end else if (flush_req && (fill_cnt != 3'd0)) begin
      if (out_free) begin
        load         = 1'b1;
        state_d      = FILL0;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
        if (accept) begin
          for (int k = 0; k < 3; k++) begin
            if (2'(k) == state_q) nib_d[k] = nib_in;
          end
          state_d = state_t'(state_q + 2'd1);
        end
      end
    end else begin
      flush_pend_d = 1'b0;
      if (accept) begin
        for (int k = 0; k < 3; k++) begin
          if (2'(k) == state_q) nib_d[k] = nib_in;
        end
        state_d = state_t'(state_q + 2'd1);
      end
    end

    if (load) begin
      word_d       = packed_word;
      word_valid_d = 1'b1;
      par_d        = ^packed_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL0;
      for (int k = 0; k < 3; k++) nib_q[k] <= 4'h0;
      word_q       <= 16'h0000;
      word_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      par_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      nib_q        <= nib_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      flush_pend_q <= flush_pend_d;
      par_q        <= par_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;

`ifdef NIBBLE_PARITY_EN
  assign word_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule
